taintcell_mem_scrubber: RTL and testbench
=========================================

// Module: taintcell_mem_scrubber
// PURPOSE
//  Controller that shares the write port of a taint-shadow memory between the functional
//  taint-write path and a scrub engine. On command, the scrub engine either clears every
//  entry (CLEAR) or walks every entry and counts the tainted ones (COUNT). It sits between
//  the PIFT shadow memories and the simulation harness, so taint can be reset or sampled
//  mid-run without a full SoC reset.
// PARAMETERS
//  ABITS     6   address width of the shadow memory
//  WIDTH     8   taint bits per entry
//  SIZE      64  number of entries; 1 <= SIZE <= 2**ABITS
//  STALL_MAX 8   starvation-guard threshold (only used with TAINT_SCRUB_GUARD_EN)
// PORTS
//  pos_clk      in  1        clock, rising edge
//  pos_arst     in  1        reset, asynchronous, active-high
//  fn_wr_valid  in  1        functional taint write request
//  fn_wr_ready  out 1        functional write accepted this cycle
//  fn_wr_addr   in  ABITS    functional write address
//  fn_wr_data   in  WIDTH    functional write taint data
//  cmd_valid    in  1        scrub command request
//  cmd_op       in  1        0 = CLEAR, 1 = COUNT
//  cmd_ready    out 1        controller idle; command accepted when valid & ready
//  mem_wr_en    out 1        memory write strobe (all WIDTH bits)
//  mem_wr_addr  out ABITS    memory write address
//  mem_wr_data  out WIDTH    memory write data
//  mem_rd_en    out 1        memory read strobe
//  mem_rd_addr  out ABITS    memory read address
//  mem_rd_data  in  WIDTH    read data, valid exactly 1 cycle after mem_rd_en
//  done         out 1        1-cycle pulse when a command completes
//  tainted_cnt  out ABITS+1  count of entries with |data != 0; result of the last COUNT
// BEHAVIOUR
//  - Reset (async): state = IDLE, cursor = 0, tainted_cnt = 0, done = 0, mem_* = 0.
//    cmd_ready = 1 and fn_wr_ready = 1 while in reset.
//  - States: IDLE, CLEAR, SCAN, DRAIN, DONE. cmd_ready = (state == IDLE).
//  - IDLE: on cmd_valid, go to CLEAR (op 0) or SCAN (op 1); cursor <= 0.
//    Accepting COUNT also sets tainted_cnt <= 0.
//  - Functional path (all states): if fn_wr_valid & fn_wr_ready, then mem_wr_en = 1 and
//    mem_wr_addr/data = fn_wr_addr/data, combinationally in the same cycle.
//    The functional path has priority over the scrub engine.
//  - CLEAR: in cycles without a functional write, drive mem_wr_en = 1,
//    mem_wr_addr = cursor, mem_wr_data = 0, and cursor++.
//    In cycles with a functional write, the cursor holds (scrub stalled).
//    After the scrub write to SIZE-1, go to DONE.
//  - SCAN: every cycle drive mem_rd_en = 1, mem_rd_addr = cursor, and cursor++. The read
//    port is independent, so functional writes never stall SCAN. After issuing SIZE-1, go to DRAIN.
//  - Count rule: tainted_cnt += (|mem_rd_data) in the cycle after each read, in both SCAN and
//    DRAIN. The count reflects the data actually returned; a same-address same-cycle
//    write/read follows the memory's read-before-write semantics.
//  - DRAIN: captures the last read result, then goes to DONE.
//  - DONE: done = 1 for exactly one cycle, then IDLE. tainted_cnt holds until the next
//    COUNT is accepted.
//  - cmd_valid while not IDLE: ignored (cmd_ready = 0); no queuing.
//  - Widths: cursor is ABITS+1 bits so it cannot wrap before SIZE; tainted_cnt saturates at SIZE.
//  - SIZE = 1: CLEAR takes 1 scrub cycle, then DONE. SCAN takes 1 issue cycle, then DRAIN, then DONE.
//  - Reset mid-operation: abort immediately. A partial clear is left as-is; the count is zeroed.
// CONFIGURATION
//  TAINT_SCRUB_GUARD_EN defined: a stall counter increments on each CLEAR cycle stalled by
//    fn_wr_valid. When it reaches STALL_MAX, the next CLEAR cycle forces fn_wr_ready = 0,
//    issues the scrub write, and resets the counter. The counter also resets on any
//    unstalled scrub write and on leaving CLEAR.
//  TAINT_SCRUB_GUARD_EN undefined: fn_wr_ready is tied to 1; CLEAR may starve indefinitely.
// TESTING
//  T1: SIZE=64, CLEAR accepted at cycle 0, no fn traffic -> mem_wr_en=1 with data 0 and
//      addr 0..63 in cycles 1..64; done pulses at cycle 65; cmd_ready=1 at cycle 66.
//  T2: entries 3, 17, 63 preloaded nonzero; COUNT -> mem_rd_addr 0..63 in cycles 1..64;
//      done at cycle 66; tainted_cnt=3, held after done.
//  T3: CLEAR with fn_wr_valid held in cycles 1..10 (addr 5, data 8'hFF) -> fn writes pass through;
//      scrub addr 0 is issued at cycle 11; done at cycle 75; entry 5 ends at 0.
//  T4: cmd_valid (COUNT) asserted mid-CLEAR -> cmd_ready=0, no SCAN afterwards,
//      tainted_cnt unchanged.
//  T5: pos_arst pulsed at cursor=20 during CLEAR -> all outputs 0 immediately, cmd_ready=1;
//      entries 20..63 untouched.
//  T6: guard on, STALL_MAX=8, fn_wr_valid held high -> every 9th CLEAR cycle has
//      fn_wr_ready=0 plus a scrub write; CLEAR finishes after 64*9 cycles.

Source files
------------

// File: rtl/taintcell_mem_scrubber.sv
// Taint-shadow memory scrubber: arbitrates the memory write port between functional taint
// writes and a CLEAR/COUNT scrub engine. Define TAINT_SCRUB_GUARD_EN for the CLEAR starvation guard.
module taintcell_mem_scrubber #(
  parameter int unsigned ABITS     = 6,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SIZE      = 64,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic             pos_clk,
  input  logic             pos_arst,
  input  logic             fn_wr_valid,
  output logic             fn_wr_ready,
  input  logic [ABITS-1:0] fn_wr_addr,
  input  logic [WIDTH-1:0] fn_wr_data,
  input  logic             cmd_valid,
  input  logic             cmd_op,
  output logic             cmd_ready,
  output logic             mem_wr_en,
  output logic [ABITS-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             mem_rd_en,
  output logic [ABITS-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             done,
  output logic [ABITS:0]   tainted_cnt
);

  localparam int unsigned    CW       = ABITS + 1;
  localparam logic [ABITS:0] LastAddr = CW'(SIZE - 1);
  localparam logic [ABITS:0] SizeCnt  = CW'(SIZE);

  if (SIZE < 1 || SIZE > (1 << ABITS) || STALL_MAX < 1) begin : gBadParams
    $error("taintcell_mem_scrubber: invalid parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StClear, StScan, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [ABITS:0] cursor_q, cursor_d;
  logic [ABITS:0] cnt_q, cnt_d;
  logic           rdPend_q, rdPend_d;
  logic           fnGrant;
  logic           scrubWr;

`ifdef TAINT_SCRUB_GUARD_EN
  localparam int unsigned SW = $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] StallLimit = SW'(STALL_MAX);
  logic [SW-1:0] stall_q, stall_d;
`endif

  always_ff @(posedge pos_clk or posedge pos_arst) begin
    if (pos_arst) begin
      state_q  <= StIdle;
      cursor_q <= '0;
      cnt_q    <= '0;
      rdPend_q <= 1'b0;
`ifdef TAINT_SCRUB_GUARD_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      rdPend_q <= rdPend_d;
`ifdef TAINT_SCRUB_GUARD_EN
      stall_q  <= stall_d;
`endif
    end
  end

  // Read data arrives one cycle after each SCAN issue, so counting trails the cursor by one.
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    cnt_d    = cnt_q;
    rdPend_d = (state_q == StScan);
    if (rdPend_q && (|mem_rd_data) && (cnt_q < SizeCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d  = cmd_op ? StScan : StClear;
          cursor_d = '0;
          if (cmd_op) begin
            cnt_d = '0;
          end
        end
      end
      StClear: begin
        if (scrubWr) begin
          cursor_d = cursor_q + 1'b1;
          if (cursor_q == LastAddr) begin
            state_d = StDone;
          end
        end
      end
      StScan: begin
        cursor_d = cursor_q + 1'b1;
        if (cursor_q == LastAddr) begin
          state_d = StDrain;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef TAINT_SCRUB_GUARD_EN
    stall_d = ((state_q == StClear) && fnGrant) ? stall_q + 1'b1 : '0;
`endif
  end

  always_comb begin
`ifdef TAINT_SCRUB_GUARD_EN
    fn_wr_ready = !((state_q == StClear) && (stall_q == StallLimit));
`else
    fn_wr_ready = 1'b1;
`endif
    fnGrant     = fn_wr_valid && fn_wr_ready;
    scrubWr     = (state_q == StClear) && !fnGrant;
    cmd_ready   = (state_q == StIdle);
    done        = (state_q == StDone);
    mem_wr_en   = fnGrant || scrubWr;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (fnGrant) begin
      mem_wr_addr = fn_wr_addr;
      mem_wr_data = fn_wr_data;
    end else if (scrubWr) begin
      mem_wr_addr = cursor_q[ABITS-1:0];
    end
    mem_rd_en   = (state_q == StScan);
    mem_rd_addr = mem_rd_en ? cursor_q[ABITS-1:0] : '0;
    tainted_cnt = cnt_q;
  end

endmodule

// File: tb/tb_taintcell_mem_scrubber.sv
// Self-checking bench for taintcell_mem_scrubber: memory model, per-cycle reference model,
// and directed CLEAR/COUNT scenarios with hand-computed timing.
module tb_taintcell_mem_scrubber;
  localparam int ABITS = 6;
  localparam int WIDTH = 8;
  localparam int SIZE = 64;
  localparam int STALL_MAX = 8;
  localparam int LOGN = 4096;
`ifdef TAINT_SCRUB_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int PH_IDLE = 0, PH_CLEARING = 1, PH_READING = 2, PH_LASTREAD = 3, PH_FINISHED = 4;

  logic             pos_clk = 1'b0;
  logic             pos_arst = 1'b1;
  logic             fn_wr_valid = 1'b0;
  logic             fn_wr_ready;
  logic [ABITS-1:0] fn_wr_addr = '0;
  logic [WIDTH-1:0] fn_wr_data = '0;
  logic             cmd_valid = 1'b0;
  logic             cmd_op = 1'b0;
  logic             cmd_ready;
  logic             mem_wr_en;
  logic [ABITS-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic             mem_rd_en;
  logic [ABITS-1:0] mem_rd_addr;
  logic [WIDTH-1:0] mem_rd_data = '0;
  logic             done;
  logic [ABITS:0]   tainted_cnt;

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] refMem [SIZE];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  int ph = PH_IDLE;
  int mNext = 0;
  int mCount = 0;
  bit mPendValid = 1'b0;
  bit mPendBit = 1'b0;
  int mStall = 0;
  bit eFnReady, eFnWrite, eWrEn, eRdEn;
  logic [ABITS-1:0] eWrAddr, eRdAddr;
  logic [WIDTH-1:0] eWrData, rdVal;

  bit               logWrEn [LOGN];
  logic [ABITS-1:0] logWrAddr [LOGN];
  logic [WIDTH-1:0] logWrData [LOGN];
  bit               logRdEn [LOGN];
  logic [ABITS-1:0] logRdAddr [LOGN];
  bit               logDone [LOGN];
  bit               logCmdReady [LOGN];
  bit               logFnReady [LOGN];
  int               logCnt [LOGN];

  taintcell_mem_scrubber #(
    .ABITS(ABITS), .WIDTH(WIDTH), .SIZE(SIZE), .STALL_MAX(STALL_MAX)
  ) dut (
    .pos_clk(pos_clk), .pos_arst(pos_arst),
    .fn_wr_valid(fn_wr_valid), .fn_wr_ready(fn_wr_ready),
    .fn_wr_addr(fn_wr_addr), .fn_wr_data(fn_wr_data),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .done(done), .tainted_cnt(tainted_cnt)
  );

  always #5 pos_clk = ~pos_clk;

  always @(posedge pos_clk) cyc = cyc + 1;

  // Shadow memory with read-before-write behaviour on a shared address.
  always @(posedge pos_clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: expected outputs from the current phase, then advance to the next cycle.
  always @(negedge pos_clk) begin
    if (pos_arst) begin
      ph = PH_IDLE; mNext = 0; mCount = 0; mPendValid = 1'b0; mPendBit = 1'b0; mStall = 0;
    end
    eFnReady = !(GUARD && ph == PH_CLEARING && mStall == STALL_MAX);
    eFnWrite = fn_wr_valid && eFnReady;
    eWrEn    = eFnWrite || (ph == PH_CLEARING);
    eWrAddr  = eFnWrite ? fn_wr_addr : 6'(mNext);
    eWrData  = eFnWrite ? fn_wr_data : 8'h00;
    eRdEn    = (ph == PH_READING);
    eRdAddr  = 6'(mNext);

    checkOutput("fn_wr_ready", 32'(fn_wr_ready), 32'(eFnReady));
    checkOutput("cmd_ready", 32'(cmd_ready), 32'(ph == PH_IDLE));
    checkOutput("done", 32'(done), 32'(ph == PH_FINISHED));
    checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(eWrEn));
    if (eWrEn) begin
      checkOutput("mem_wr_addr", 32'(mem_wr_addr), 32'(eWrAddr));
      checkOutput("mem_wr_data", 32'(mem_wr_data), 32'(eWrData));
    end
    checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(eRdEn));
    if (eRdEn) checkOutput("mem_rd_addr", 32'(mem_rd_addr), 32'(eRdAddr));
    checkOutput("tainted_cnt", 32'(tainted_cnt), 32'(mCount));

    if (cyc < LOGN) begin
      logWrEn[cyc] = mem_wr_en; logWrAddr[cyc] = mem_wr_addr; logWrData[cyc] = mem_wr_data;
      logRdEn[cyc] = mem_rd_en; logRdAddr[cyc] = mem_rd_addr; logDone[cyc] = done;
      logCmdReady[cyc] = cmd_ready; logFnReady[cyc] = fn_wr_ready; logCnt[cyc] = int'(tainted_cnt);
    end

    if (!pos_arst) begin
      rdVal = eRdEn ? refMem[eRdAddr] : 8'h00;
      if (mPendValid && mPendBit && mCount < SIZE) mCount++;
      mPendValid = eRdEn;
      mPendBit   = eRdEn && (rdVal != 8'h00);
      if (eWrEn) refMem[eWrAddr] = eWrData;
      case (ph)
        PH_IDLE: if (cmd_valid) begin
          ph = cmd_op ? PH_READING : PH_CLEARING;
          mNext = 0;
          if (cmd_op) mCount = 0;
        end
        PH_CLEARING: begin
          if (eFnWrite) mStall++;
          else begin
            mStall = 0;
            mNext++;
            if (mNext == SIZE) ph = PH_FINISHED;
          end
        end
        PH_READING: begin
          mNext++;
          if (mNext == SIZE) ph = PH_LASTREAD;
        end
        PH_LASTREAD: ph = PH_FINISHED;
        default: ph = PH_IDLE;
      endcase
    end
  end

  // Drive inputs at posedge+1 and hold them for n cycles.
  task automatic applyStimulus(input bit fv, input logic [5:0] fa, input logic [7:0] fd,
                               input bit cv, input bit op, input int n);
    fn_wr_valid = fv; fn_wr_addr = fa; fn_wr_data = fd; cmd_valid = cv; cmd_op = op;
    repeat (n) @(posedge pos_clk);
    #1;
  endtask

  task automatic loadMem(input logic [7:0] v);
    for (int i = 0; i < SIZE; i++) begin
      mem[i] = v; refMem[i] = v;
    end
  endtask

  task automatic setEntry(input int a, input logic [7:0] v);
    mem[a] = v; refMem[a] = v;
  endtask

  task automatic checkMemory(input string name);
    int bad = 0;
    for (int i = 0; i < SIZE; i++) if (mem[i] !== refMem[i]) bad++;
    checkOutput(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    loadMem(8'h00);
    repeat (3) @(posedge pos_clk);
    #2;
    checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset fn_wr_ready", 32'(fn_wr_ready), 32'd1);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("reset tainted_cnt", 32'(tainted_cnt), 32'd0);
    pos_arst = 1'b0;
    @(posedge pos_clk); #1;

    $display("[TB] T1 CLEAR without functional traffic");
    loadMem(8'h3C);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 69);
    checkOutput("T1 first scrub en", 32'(logWrEn[t0+1]), 32'd1);
    checkOutput("T1 first scrub addr", 32'(logWrAddr[t0+1]), 32'd0);
    checkOutput("T1 last scrub addr", 32'(logWrAddr[t0+64]), 32'd63);
    checkOutput("T1 no write after", 32'(logWrEn[t0+65]), 32'd0);
    checkOutput("T1 done early", 32'(logDone[t0+64]), 32'd0);
    checkOutput("T1 done", 32'(logDone[t0+65]), 32'd1);
    checkOutput("T1 ready during done", 32'(logCmdReady[t0+65]), 32'd0);
    checkOutput("T1 ready after", 32'(logCmdReady[t0+66]), 32'd1);
    n = 0;
    for (int i = 0; i < SIZE; i++) if (mem[i] != 8'h00) n++;
    checkOutput("T1 entries left tainted", 32'(n), 32'd0);
    checkMemory("T1 memory");

    $display("[TB] T2 COUNT with three tainted entries");
    loadMem(8'h00);
    setEntry(3, 8'h01); setEntry(17, 8'h80); setEntry(63, 8'h55);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 70);
    checkOutput("T2 first read en", 32'(logRdEn[t0+1]), 32'd1);
    checkOutput("T2 first read addr", 32'(logRdAddr[t0+1]), 32'd0);
    checkOutput("T2 last read addr", 32'(logRdAddr[t0+64]), 32'd63);
    checkOutput("T2 no read in drain", 32'(logRdEn[t0+65]), 32'd0);
    checkOutput("T2 done early", 32'(logDone[t0+65]), 32'd0);
    checkOutput("T2 done", 32'(logDone[t0+66]), 32'd1);
    checkOutput("T2 partial count", 32'(logCnt[t0+65]), 32'd2);
    checkOutput("T2 count at done", 32'(logCnt[t0+66]), 32'd3);
    checkOutput("T2 count held", 32'(logCnt[t0+70]), 32'd3);

    $display("[TB] T3 CLEAR stalled by functional writes");
    loadMem(8'h11);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(1, 6'd5, 8'hFF, 0, 0, 10);
    applyStimulus(0, 0, 0, 0, 0, 70);
    checkOutput("T3 fn write addr", 32'(logWrAddr[t0+1]), 32'd5);
    checkOutput("T3 fn write data", 32'(logWrData[t0+1]), 32'hFF);
    checkOutput("T3 last stalled addr", 32'(logWrAddr[t0+10]), 32'd5);
    checkOutput("T3 first scrub addr", 32'(logWrAddr[t0+11]), 32'd0);
    checkOutput("T3 first scrub data", 32'(logWrData[t0+11]), 32'd0);
    checkOutput("T3 done early", 32'(logDone[t0+74]), 32'd0);
    checkOutput("T3 done", 32'(logDone[t0+75]), 32'd1);
    checkOutput("T3 entry 5", 32'(mem[5]), 32'd0);
    checkMemory("T3 memory");

    $display("[TB] T4 COUNT command during CLEAR is ignored");
    loadMem(8'h07);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 9);
    applyStimulus(0, 0, 0, 1, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 67);
    checkOutput("T4 cmd_ready mid clear", 32'(logCmdReady[t0+10]), 32'd0);
    n = 0;
    for (int k = 0; k < 80; k++) if (logRdEn[t0+k]) n++;
    checkOutput("T4 reads issued", 32'(n), 32'd0);
    checkOutput("T4 done", 32'(logDone[t0+65]), 32'd1);
    checkOutput("T4 count unchanged", 32'(logCnt[t0+79]), 32'd3);

    $display("[TB] T7 COUNT with concurrent functional writes");
    loadMem(8'h00);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 4);
    applyStimulus(1, 6'd4, 8'hFF, 0, 0, 1);
    applyStimulus(1, 6'd40, 8'h01, 0, 0, 1);
    applyStimulus(1, 6'd2, 8'h01, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 66);
    checkOutput("T7 same-addr read", 32'(logRdAddr[t0+5]), 32'd4);
    checkOutput("T7 same-addr write", 32'(logWrAddr[t0+5]), 32'd4);
    checkOutput("T7 count", 32'(logCnt[t0+70]), 32'd1);
    checkMemory("T7 memory");

    $display("[TB] T5 full COUNT then reset mid-CLEAR");
    loadMem(8'hA5);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 71);
    checkOutput("T5 all tainted count", 32'(logCnt[t0+70]), 32'd64);
    t0 = cyc;
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 20);
    checkOutput("T5 scrub before reset", 32'(logWrAddr[t0+20]), 32'd19);
    #1;
    pos_arst = 1'b1;
    #1;
    checkOutput("T5 mem_wr_en in reset", 32'(mem_wr_en), 32'd0);
    checkOutput("T5 mem_wr_addr in reset", 32'(mem_wr_addr), 32'd0);
    checkOutput("T5 done in reset", 32'(done), 32'd0);
    checkOutput("T5 cmd_ready in reset", 32'(cmd_ready), 32'd1);
    checkOutput("T5 count in reset", 32'(tainted_cnt), 32'd0);
    @(posedge pos_clk); #1;
    pos_arst = 1'b0;
    @(posedge pos_clk); #1;
    n = 0;
    for (int i = 0; i < 20; i++) if (mem[i] == 8'h00) n++;
    checkOutput("T5 cleared entries", 32'(n), 32'd20);
    n = 0;
    for (int i = 20; i < SIZE; i++) if (mem[i] == 8'hA5) n++;
    checkOutput("T5 untouched entries", 32'(n), 32'd44);
    checkMemory("T5 memory");

`ifdef TAINT_SCRUB_GUARD_EN
    $display("[TB] T6 starvation guard with continuous functional writes");
    loadMem(8'h22);
    t0 = cyc;
    applyStimulus(1, 6'd7, 8'h01, 1, 0, 1);
    applyStimulus(1, 6'd7, 8'h01, 0, 0, 578);
    applyStimulus(0, 0, 0, 0, 0, 5);
    checkOutput("T6 ready before guard", 32'(logFnReady[t0+8]), 32'd1);
    checkOutput("T6 guard blocks fn", 32'(logFnReady[t0+9]), 32'd0);
    checkOutput("T6 forced scrub addr", 32'(logWrAddr[t0+9]), 32'd0);
    checkOutput("T6 ready after guard", 32'(logFnReady[t0+10]), 32'd1);
    checkOutput("T6 second forced scrub", 32'(logWrAddr[t0+18]), 32'd1);
    checkOutput("T6 last forced scrub", 32'(logWrAddr[t0+576]), 32'd63);
    checkOutput("T6 done", 32'(logDone[t0+577]), 32'd1);
    checkMemory("T6 memory");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
